// File: rtl/hs_fifo_with_param.sv
// hs_fifo_with_param: valid/ready handshaked first-word-fall-through FIFO.
// Buffers a DATA_WIDTH-wide stream ahead of the multi-config passthrough
// wrapper. Occupancy is tracked in a registered count, so both handshake
// flags are pure functions of state. There is no combinational path from
// dataIn_vld to dataIn_rd, or from dataOut_rd to dataOut_vld.
module hs_fifo_with_param #(
   parameter int DATA_WIDTH = 2,
   parameter int DEPTH      = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [DATA_WIDTH-1:0]          dataIn_data,
   input  logic                           dataIn_vld,
   output logic                           dataIn_rd,
   output logic [DATA_WIDTH-1:0]          dataOut_data,
   output logic                           dataOut_vld,
   input  logic                           dataOut_rd,
   output logic [$clog2(DEPTH+1)-1:0]     size
);

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

   if (DEPTH < 2 || DEPTH > 256) begin : g_bad_depth
      $error("%m unsupported DEPTH");
   end

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [CNT_W-1:0]      count;
   logic                  push;
   logic                  pop;

   // Pointers wrap with an explicit compare, so non-power-of-two depths work.
   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + 1'b1;
   endfunction

   // Handshake flags come from the registered count only. While reset is
   // held, intake is blocked, so nothing can be pushed during reset.
   always_comb begin
      dataIn_rd    = (count != FULL_CNT) & ~rst;
      dataOut_vld  = (count != '0);
      dataOut_data = mem[rd_ptr];
      size         = count;
      push         = dataIn_vld & dataIn_rd;
      pop          = dataOut_vld & dataOut_rd;
   end

   // Storage array: written at the tail on push, cleared by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (push) begin
         mem[wr_ptr] <= dataIn_data;
      end
   end

   // Pointer and occupancy bookkeeping. A push and a pop on the same edge
   // advance both pointers and leave the count unchanged.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= next_ptr(wr_ptr);
         if (pop)  rd_ptr <= next_ptr(rd_ptr);
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_hs_fifo_with_param.sv
// Testbench for hs_fifo_with_param. It uses three instances:
//   u0: DATA_WIDTH=2, DEPTH=4
//   u1: DATA_WIDTH=3, DEPTH=3
//   u2: DATA_WIDTH=4, DEPTH=5
// Each instance is checked against a queue model. Accepted words are pushed
// to the queue, and the DUT head is compared with the queue front.
module tb_hs_fifo_with_param;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic       vin  [3];
   logic       rin  [3];
   logic [3:0] din  [3];

   logic       ird0, ovld0;
   logic [1:0] od0;
   logic [2:0] sz0;
   logic       ird1, ovld1;
   logic [2:0] od1;
   logic [1:0] sz1;
   logic       ird2, ovld2;
   logic [3:0] od2;
   logic [2:0] sz2;

   hs_fifo_with_param #(.DATA_WIDTH(2), .DEPTH(4)) u0 (
      .clk(clk), .rst(rst),
      .dataIn_data(din[0][1:0]), .dataIn_vld(vin[0]), .dataIn_rd(ird0),
      .dataOut_data(od0), .dataOut_vld(ovld0), .dataOut_rd(rin[0]),
      .size(sz0));

   hs_fifo_with_param #(.DATA_WIDTH(3), .DEPTH(3)) u1 (
      .clk(clk), .rst(rst),
      .dataIn_data(din[1][2:0]), .dataIn_vld(vin[1]), .dataIn_rd(ird1),
      .dataOut_data(od1), .dataOut_vld(ovld1), .dataOut_rd(rin[1]),
      .size(sz1));

   hs_fifo_with_param #(.DATA_WIDTH(4), .DEPTH(5)) u2 (
      .clk(clk), .rst(rst),
      .dataIn_data(din[2]), .dataIn_vld(vin[2]), .dataIn_rd(ird2),
      .dataOut_data(od2), .dataOut_vld(ovld2), .dataOut_rd(rin[2]),
      .size(sz2));

   logic [3:0] q0[$];
   logic [3:0] q1[$];
   logic [3:0] q2[$];

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle on instance k, then check the pre-edge state at the
   // negedge and update the model for the edge that follows.
   task automatic cycle(input int k, input logic v, input logic [3:0] d,
                        input logic r, output logic acc);
      logic       o_rd, o_vld;
      logic [3:0] o_d, o_sz, mask, front;
      int         depth, cnt;
      logic       push, pop;
      vin[k] = v;
      din[k] = d;
      rin[k] = r;
      @(negedge clk);
      case (k)
         0: begin o_rd = ird0; o_vld = ovld0; o_d = {2'b00, od0}; o_sz = {1'b0, sz0};
                  depth = 4; mask = 4'h3; cnt = q0.size(); front = (cnt != 0) ? q0[0] : 4'h0; end
         1: begin o_rd = ird1; o_vld = ovld1; o_d = {1'b0, od1};  o_sz = {2'b00, sz1};
                  depth = 3; mask = 4'h7; cnt = q1.size(); front = (cnt != 0) ? q1[0] : 4'h0; end
         default: begin o_rd = ird2; o_vld = ovld2; o_d = od2; o_sz = {1'b0, sz2};
                  depth = 5; mask = 4'hf; cnt = q2.size(); front = (cnt != 0) ? q2[0] : 4'h0; end
      endcase
      check($sformatf("u%0d_size", k), 32'(o_sz), 32'(cnt));
      check($sformatf("u%0d_in_rd", k), 32'(o_rd), 32'(cnt != depth));
      check($sformatf("u%0d_out_vld", k), 32'(o_vld), 32'(cnt != 0));
      if (cnt != 0) check($sformatf("u%0d_head", k), 32'(o_d), 32'(front));
      push = v && (cnt != depth);
      pop  = r && (cnt != 0);
      case (k)
         0: begin if (pop) void'(q0.pop_front()); if (push) q0.push_back(d & mask); end
         1: begin if (pop) void'(q1.pop_front()); if (push) q1.push_back(d & mask); end
         default: begin if (pop) void'(q2.pop_front()); if (push) q2.push_back(d & mask); end
      endcase
      acc = push;
      @(posedge clk);
      #1;
   endtask

   logic acc;
   int   pushed;
   int   guard;

   initial begin
      for (int i = 0; i < 3; i++) begin
         vin[i] = 1'b0;
         rin[i] = 1'b0;
         din[i] = 4'h0;
      end
      rst = 1'b1;
      #12;
      // Reset state, after a clock edge with rst held high.
      check("rst_in_rd", 32'(ird0), 32'(0));
      check("rst_out_vld", 32'(ovld0), 32'(0));
      check("rst_size", 32'(sz0), 32'(0));
      check("rst_data", 32'(od0), 32'(0));
      #1 rst = 1'b0;
      @(posedge clk); #1;

      // 1: idle after reset.
      cycle(0, 1'b0, 4'h0, 1'b0, acc);
      check("idle_data", 32'(od0), 32'(0));

      // 2: fill to full with 1,2,3,0, then offer a 5th word (1).
      cycle(0, 1'b1, 4'h1, 1'b0, acc);
      cycle(0, 1'b1, 4'h2, 1'b0, acc);
      cycle(0, 1'b1, 4'h3, 1'b0, acc);
      cycle(0, 1'b1, 4'h0, 1'b0, acc);
      cycle(0, 1'b1, 4'h1, 1'b0, acc);
      check("full_5th_held", 32'(acc), 32'(0));

      // 3: from full, pop while streaming 3,2,1.
      cycle(0, 1'b1, 4'h3, 1'b1, acc);
      check("full_pop_only", 32'(acc), 32'(0));
      cycle(0, 1'b1, 4'h2, 1'b1, acc);
      cycle(0, 1'b1, 4'h1, 1'b1, acc);
      for (int i = 0; i < 8; i++) cycle(0, 1'b0, 4'h0, 1'b1, acc);
      cycle(0, 1'b0, 4'h0, 1'b0, acc);

      // 4: streaming with both sides always ready, DEPTH=3.
      for (int i = 0; i < 20; i++) cycle(1, 1'b1, 4'($urandom_range(0, 7)), 1'b1, acc);
      cycle(1, 1'b0, 4'h0, 1'b1, acc);
      cycle(1, 1'b0, 4'h0, 1'b0, acc);

      // 5: random stalls on both sides, DEPTH=5.
      pushed = 0;
      guard  = 0;
      while (pushed < 1000 && guard < 20000) begin
         cycle(2, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
               1'($urandom_range(0, 1)), acc);
         if (acc) pushed++;
         guard++;
      end
      check("rand_words_pushed", 32'(pushed), 32'(1000));
      guard = 0;
      while (q2.size() != 0 && guard < 100) begin
         cycle(2, 1'b0, 4'h0, 1'b1, acc);
         guard++;
      end
      check("rand_drained", 32'(q2.size()), 32'(0));
      cycle(2, 1'b0, 4'h0, 1'b0, acc);

      // 6: asynchronous reset mid-cycle with three words buffered.
      cycle(0, 1'b1, 4'h1, 1'b0, acc);
      cycle(0, 1'b1, 4'h2, 1'b0, acc);
      cycle(0, 1'b1, 4'h3, 1'b0, acc);
      vin[0] = 1'b0;
      check("pre_rst_size", 32'(sz0), 32'(3));
      #2 rst = 1'b1;
      #1;
      check("async_rst_vld", 32'(ovld0), 32'(0));
      check("async_rst_size", 32'(sz0), 32'(0));
      check("async_rst_in_rd", 32'(ird0), 32'(0));
      check("async_rst_data", 32'(od0), 32'(0));
      q0.delete();
      q1.delete();
      q2.delete();
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      cycle(0, 1'b1, 4'h2, 1'b0, acc);
      cycle(0, 1'b1, 4'h3, 1'b0, acc);
      check("post_rst_first", 32'(od0), 32'(2));
      cycle(0, 1'b0, 4'h0, 1'b1, acc);
      cycle(0, 1'b0, 4'h0, 1'b1, acc);
      cycle(0, 1'b0, 4'h0, 1'b0, acc);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Watchdog: if the bench never reaches its summary line, report and stop.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
